// File: rtl/cpu_pkg.sv
// Shared stack-CPU definitions: instruction width, opcodes, memory-mapped
// addresses, and the program loader state encoding.
package cpu_pkg;

    localparam int INSTR_W = 12;

    localparam logic [3:0] OP_PUSHC = 4'd0;
    localparam logic [3:0] OP_PUSH  = 4'd1;
    localparam logic [3:0] OP_POP   = 4'd2;
    localparam logic [3:0] OP_JUMP  = 4'd3;
    localparam logic [3:0] OP_ADD   = 4'd6;
    localparam logic [3:0] OP_SUB   = 4'd7;

    localparam logic [7:0] ADDR_X = 8'hF8;
    localparam logic [7:0] ADDR_Y = 8'hFF;

    typedef enum logic [2:0] {
        LD_HDR,
        LD_PAYLOAD,
        LD_CHECK,
        LD_RUN,
        LD_ERR
    } load_state_t;

    // Payload length in bytes for count byte C: ceil(3*(C+1)/2).
    function automatic logic [9:0] payload_bytes(input logic [7:0] count);
        logic [9:0] n;
        n = {2'b00, count} + 10'd1;
        return (n + n + n + 10'd1) >> 1;
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte stream in, instruction memory write port out. The loader is the
// slave on the stream and drives the memory write side.
interface program_loader_if #(parameter int ADDR_W = 8);

    logic [7:0]                  in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic                        imem_we;
    logic [ADDR_W-1:0]           imem_addr;
    logic [cpu_pkg::INSTR_W-1:0] imem_wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/program_loader_packer.sv
// byte_packer: unpacks groups of three bytes into two 12-bit words, emitting
// a registered word with a one-cycle valid strobe.
module byte_packer
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         byte_data,
    input  logic               byte_valid,
    output logic [INSTR_W-1:0] word,
    output logic               word_valid
);

    logic [1:0] phase;
    logic [7:0] b0;
    logic [3:0] b1_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase      <= 2'd0;
            b0         <= 8'd0;
            b1_lo      <= 4'd0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (byte_valid) begin
                case (phase)
                    2'd0: begin
                        b0    <= byte_data;
                        phase <= 2'd1;
                    end
                    2'd1: begin
                        word       <= {b0, byte_data[7:4]};
                        word_valid <= 1'b1;
                        b1_lo      <= byte_data[3:0];
                        phase      <= 2'd2;
                    end
                    2'd2: begin
                        word       <= {b1_lo, byte_data};
                        word_valid <= 1'b1;
                        phase      <= 2'd0;
                    end
                    default: phase <= 2'd0;
                endcase
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a header/payload[/checksum] byte stream into instruction memory and
// holds the CPU in reset until done. Checksum byte enabled by PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    program_loader_if.slave  bus,
    output logic             cpu_reset,
    output logic             done,
    output logic             error
);

    localparam logic [31:0] DEPTH = 32'(1) << ADDR_W;

    load_state_t        state, state_next;
    logic               accept;
    logic               last_byte;
    logic [9:0]         nbytes;
    logic [9:0]         byte_cnt;
    logic [ADDR_W-1:0]  wa;
    logic               pk_valid;
    logic [INSTR_W-1:0] pk_word;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic       sum_ok;
    assign sum_ok = (8'(sum + bus.in_data) == 8'd0);
`endif

    assign bus.in_ready = (state == LD_HDR) || (state == LD_PAYLOAD) || (state == LD_CHECK);
    assign accept       = bus.in_valid && bus.in_ready;
    assign last_byte    = (byte_cnt == nbytes - 10'd1);

    always_comb begin
        state_next = state;
        case (state)
            LD_HDR:
                if (accept)
                    state_next = (32'(bus.in_data) >= DEPTH) ? LD_ERR : LD_PAYLOAD;
            LD_PAYLOAD:
                if (accept && last_byte)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    state_next = LD_CHECK;
`else
                    state_next = LD_RUN;
`endif
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            LD_CHECK:
                if (accept)
                    state_next = sum_ok ? LD_RUN : LD_ERR;
`endif
            LD_RUN:  state_next = LD_RUN;
            LD_ERR:  state_next = LD_ERR;
            default: state_next = LD_HDR;
        endcase
    end

    // Status outputs follow the state register, so done trails the last
    // write pulse by at least one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LD_HDR;
            nbytes    <= 10'd0;
            byte_cnt  <= 10'd0;
            wa        <= '0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_next;
            cpu_reset <= (state != LD_RUN);
            done      <= (state == LD_RUN);
            error     <= (state == LD_ERR);
            if (accept && state == LD_HDR)
                nbytes <= payload_bytes(bus.in_data);
            if (accept && state == LD_PAYLOAD)
                byte_cnt <= byte_cnt + 10'd1;
            if (pk_valid)
                wa <= wa + 1'b1;
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset)
            sum <= 8'd0;
        else if (accept && state == LD_HDR)
            sum <= bus.in_data;
        else if (accept && state == LD_PAYLOAD)
            sum <= 8'(sum + bus.in_data);
    end
`endif

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .byte_data  (bus.in_data),
        .byte_valid (accept && state == LD_PAYLOAD),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

    assign bus.imem_we    = pk_valid;
    assign bus.imem_wdata = pk_word;
    assign bus.imem_addr  = wa;

endmodule
